clock_div_multi: RTL and testbench

CLOCK_DIV_MULTI -- requirements
Module: clock_div_multi

---
 rtl/clock_div_multi.sv | 135 +++++++++++++
 tb/tb_clock_div_multi.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider with per-channel bypass and a shared phase-align sync.
// Each channel produces a D-cycle divided clock, high for ceil(D/2) cycles, plus a period-start tick.
module clock_div_multi #(
   parameter int unsigned SIZE = 3,
   parameter int unsigned NCH  = 2
) (
   input  logic                in,
   input  logic                reset,
   input  logic [NCH*SIZE-1:0] N,
   input  logic [NCH-1:0]      enable,
   input  logic                sync,
   output logic [NCH-1:0]      out,
   output logic [NCH-1:0]      tick,
   output logic [NCH-1:0]      running
);

   localparam int unsigned W = SIZE + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      BYP  = 2'd2
   } state_t;

   state_t          state    [NCH];
   state_t          state_nx [NCH];
   logic [SIZE-1:0] cnt      [NCH];
   logic [SIZE-1:0] cnt_nx   [NCH];
   logic [SIZE-1:0] act      [NCH];
   logic [SIZE-1:0] act_nx   [NCH];
   logic [SIZE-1:0] div      [NCH];
   logic [NCH-1:0]  q;
   logic [NCH-1:0]  q_nx;
   logic [NCH-1:0]  tick_q;
   logic [NCH-1:0]  tick_nx;
   logic [NCH-1:0]  start;

   // State register; all channel state lives here and updates on the source clock.
   always_ff @(posedge in) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            state[c] <= IDLE;
            cnt[c]   <= '0;
            act[c]   <= '0;
         end
         q      <= '0;
         tick_q <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            state[c] <= state_nx[c];
            cnt[c]   <= cnt_nx[c];
            act[c]   <= act_nx[c];
         end
         q      <= q_nx;
         tick_q <= tick_nx;
      end
   end

   // Next-state logic; a period start latches N so the running period always uses the old divisor.
   always_comb begin
      start   = '0;
      q_nx    = q;
      tick_nx = tick_q;
      for (int c = 0; c < NCH; c++) begin
         state_nx[c] = state[c];
         cnt_nx[c]   = cnt[c];
         act_nx[c]   = act[c];
         div[c]      = N[c*SIZE +: SIZE];

         case (state[c])
            IDLE: begin
               q_nx[c]    = 1'b0;
               tick_nx[c] = 1'b0;
               if (enable[c]) start[c] = 1'b1;
            end
            RUN: begin
               if (sync) begin
                  start[c] = 1'b1;
               end else if (cnt[c] == act[c] - SIZE'(1)) begin
                  if (enable[c]) begin
                     start[c] = 1'b1;
                  end else begin
                     state_nx[c] = IDLE;
                     cnt_nx[c]   = '0;
                     q_nx[c]     = 1'b0;
                     tick_nx[c]  = 1'b0;
                  end
               end else begin
                  cnt_nx[c]  = cnt[c] + SIZE'(1);
                  q_nx[c]    = (W'(cnt[c]) + W'(1)) < ((W'(act[c]) + W'(1)) >> 1);
                  tick_nx[c] = 1'b0;
               end
            end
            BYP: begin
               tick_nx[c] = 1'b1;
               if (!enable[c]) begin
                  state_nx[c] = IDLE;
                  q_nx[c]     = 1'b0;
                  tick_nx[c]  = 1'b0;
               end else if (div[c] >= SIZE'(2)) begin
                  start[c] = 1'b1;
               end
            end
            default: begin
               state_nx[c] = IDLE;
               q_nx[c]     = 1'b0;
               tick_nx[c]  = 1'b0;
            end
         endcase

         if (start[c]) begin
            act_nx[c]  = div[c];
            cnt_nx[c]  = '0;
            tick_nx[c] = 1'b1;
            if (div[c] <= SIZE'(1)) begin
               state_nx[c] = BYP;
               q_nx[c]     = 1'b0;
            end else begin
               state_nx[c] = RUN;
               q_nx[c]     = 1'b1;
            end
         end
      end
   end

   // Output select is the registered state, so passthrough switches only at a rising edge of in.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         out[c]     = !reset && ((state[c] == BYP) ? in : q[c]);
         tick[c]    = !reset && tick_q[c];
         running[c] = !reset && (state[c] != IDLE);
      end
   end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi (SIZE=3, NCH=2): reset, duty, divisor change,
// bypass entry/exit, disable, sync alignment and reset override.
module tb_clock_div_multi;

   logic       clk;
   logic       reset;
   logic [5:0] n_bus;
   logic [1:0] enable;
   logic       sync;
   logic [1:0] out_v;
   logic [1:0] tick_v;
   logic [1:0] run_v;

   int checks;
   int errors;

   clock_div_multi #(.SIZE(3), .NCH(2)) dut (
      .in      (clk),
      .reset   (reset),
      .N       (n_bus),
      .enable  (enable),
      .sync    (sync),
      .out     (out_v),
      .tick    (tick_v),
      .running (run_v)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      sync   = 1'b0;
      enable = 2'b00;
      step();
      step();
      reset  = 1'b0;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      enable = 2'b11;
      n_bus  = {3'd2, 3'd3};
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out_v !== 2'b00) begin
            errors++;
            $display("FAIL reset_out edge %0d got %b want 00", i, out_v);
         end
         checks++;
         if (tick_v !== 2'b00) begin
            errors++;
            $display("FAIL reset_tick edge %0d got %b want 00", i, tick_v);
         end
         checks++;
         if (run_v !== 2'b00) begin
            errors++;
            $display("FAIL reset_running edge %0d got %b want 00", i, run_v);
         end
      end
   endtask

   task automatic test_div3();
      logic [5:0] eo;
      logic [5:0] et;
      eo = 6'b110110;
      et = 6'b100100;
      n_bus  = {3'd0, 3'd3};
      enable = 2'b01;
      reset  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (out_v !== {1'b0, eo[5-i]}) begin
            errors++;
            $display("FAIL div3_out cycle %0d got %b want %b", i, out_v, {1'b0, eo[5-i]});
         end
         checks++;
         if (tick_v !== {1'b0, et[5-i]}) begin
            errors++;
            $display("FAIL div3_tick cycle %0d got %b want %b", i, tick_v, {1'b0, et[5-i]});
         end
         checks++;
         if (run_v !== 2'b01) begin
            errors++;
            $display("FAIL div3_running cycle %0d got %b want 01", i, run_v);
         end
      end
   endtask

   task automatic test_n_change();
      logic [13:0] eo;
      logic [13:0] et;
      eo = 14'b11001100111001;
      et = 14'b10001000100001;
      n_bus[5:3] = 3'd4;
      enable     = 2'b11;
      for (int i = 0; i < 14; i++) begin
         step();
         checks++;
         if (out_v[1] !== eo[13-i]) begin
            errors++;
            $display("FAIL nchg_out1 cycle %0d got %b want %b", i, out_v[1], eo[13-i]);
         end
         checks++;
         if (tick_v[1] !== et[13-i]) begin
            errors++;
            $display("FAIL nchg_tick1 cycle %0d got %b want %b", i, tick_v[1], et[13-i]);
         end
         if (i == 5) n_bus[5:3] = 3'd5;
      end
   endtask

   task automatic test_n_shrink();
      logic [6:0] eo;
      logic [6:0] et;
      eo = 7'b1101010;
      et = 7'b1001010;
      do_reset();
      n_bus  = {3'd0, 3'd3};
      enable = 2'b01;
      for (int i = 0; i < 7; i++) begin
         step();
         checks++;
         if (out_v[0] !== eo[6-i]) begin
            errors++;
            $display("FAIL shrink_out0 cycle %0d got %b want %b", i, out_v[0], eo[6-i]);
         end
         checks++;
         if (tick_v[0] !== et[6-i]) begin
            errors++;
            $display("FAIL shrink_tick0 cycle %0d got %b want %b", i, tick_v[0], et[6-i]);
         end
         if (i == 0) n_bus[2:0] = 3'd2;
      end
   endtask

   // Runs straight after test_n_shrink, with ch0 on the last cycle of a 2-cycle period.
   task automatic test_bypass();
      n_bus[2:0] = 3'd0;
      step();
      checks++;
      if (out_v[0] !== 1'b1 || tick_v[0] !== 1'b1 || run_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL byp_enter_high got out=%b tick=%b run=%b want 1 1 1", out_v[0], tick_v[0], run_v[0]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_v[0] !== 1'b0 || tick_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL byp_low_phase got out=%b tick=%b want 0 1", out_v[0], tick_v[0]);
      end
      step();
      checks++;
      if (out_v[0] !== 1'b1 || tick_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL byp_hold got out=%b tick=%b want 1 1", out_v[0], tick_v[0]);
      end
      n_bus[2:0] = 3'd2;
      step();
      checks++;
      if (out_v[0] !== 1'b1 || tick_v[0] !== 1'b1 || run_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL byp_exit_start got out=%b tick=%b run=%b want 1 1 1", out_v[0], tick_v[0], run_v[0]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL byp_exit_no_glitch got out=%b want 1", out_v[0]);
      end
      enable = 2'b00;
      step();
      checks++;
      if (out_v[0] !== 1'b0 || tick_v[0] !== 1'b0 || run_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL disable_finish got out=%b tick=%b run=%b want 0 0 1", out_v[0], tick_v[0], run_v[0]);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (out_v[0] !== 1'b0 || tick_v[0] !== 1'b0 || run_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL disable_idle cycle %0d got out=%b tick=%b run=%b want 0 0 0", i, out_v[0], tick_v[0], run_v[0]);
         end
      end
   endtask

   task automatic test_sync();
      do_reset();
      n_bus  = {3'd5, 3'd3};
      enable = 2'b01;
      step();
      enable = 2'b11;
      step();
      checks++;
      if (tick_v !== 2'b10) begin
         errors++;
         $display("FAIL sync_offset_tick got %b want 10", tick_v);
      end
      step();
      checks++;
      if (out_v !== 2'b10) begin
         errors++;
         $display("FAIL sync_before_out got %b want 10", out_v);
      end
      sync = 1'b1;
      step();
      sync = 1'b0;
      checks++;
      if (out_v !== 2'b11) begin
         errors++;
         $display("FAIL sync_align_out got %b want 11", out_v);
      end
      checks++;
      if (tick_v !== 2'b11) begin
         errors++;
         $display("FAIL sync_align_tick got %b want 11", tick_v);
      end
      step();
      checks++;
      if (out_v !== 2'b11 || tick_v !== 2'b00) begin
         errors++;
         $display("FAIL sync_after1 got out=%b tick=%b want 11 00", out_v, tick_v);
      end
      step();
      checks++;
      if (out_v !== 2'b10) begin
         errors++;
         $display("FAIL sync_after2 got %b want 10", out_v);
      end
   endtask

   task automatic test_reset_override();
      do_reset();
      n_bus  = {3'd0, 3'd1};
      enable = 2'b01;
      step();
      checks++;
      if (out_v !== 2'b01 || tick_v !== 2'b01 || run_v !== 2'b01) begin
         errors++;
         $display("FAIL ovr_byp got out=%b tick=%b run=%b want 01 01 01", out_v, tick_v, run_v);
      end
      reset  = 1'b1;
      sync   = 1'b1;
      enable = 2'b11;
      #1;
      checks++;
      if (out_v !== 2'b00 || tick_v !== 2'b00 || run_v !== 2'b00) begin
         errors++;
         $display("FAIL ovr_reset_level got out=%b tick=%b run=%b want 00 00 00", out_v, tick_v, run_v);
      end
      step();
      checks++;
      if (out_v !== 2'b00 || tick_v !== 2'b00 || run_v !== 2'b00) begin
         errors++;
         $display("FAIL ovr_reset_edge got out=%b tick=%b run=%b want 00 00 00", out_v, tick_v, run_v);
      end
      reset      = 1'b0;
      sync       = 1'b0;
      enable     = 2'b01;
      n_bus[2:0] = 3'd3;
      step();
      checks++;
      if (out_v !== 2'b01 || tick_v !== 2'b01 || run_v !== 2'b01) begin
         errors++;
         $display("FAIL ovr_first_start got out=%b tick=%b run=%b want 01 01 01", out_v, tick_v, run_v);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clk    = 1'b0;
      reset  = 1'b1;
      enable = 2'b00;
      n_bus  = '0;
      sync   = 1'b0;
      test_reset();
      test_div3();
      test_n_change();
      test_n_shrink();
      test_bypass();
      test_sync();
      test_reset_override();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
